// File: rtl/vip_pkg.sv
// Shared definitions for the VIP gray stream generator: pattern codes,
// FSM state encoding and a counter-width helper.
package vip_pkg;

  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_VS_LEAD    = 3'd1,
    ST_LINE_ACT   = 3'd2,
    ST_LINE_BLANK = 3'd3,
    ST_V_BLANK    = 3'd4
  } state_t;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vip_gray_stream_gen_if.sv
// Camera-style gray video stream: frame valid, line valid, pixel strobe, Y.
interface vip_gray_stream_gen_if;
  // Push-only stream with no back-pressure: per_img_Y is meaningful only in
  // a cycle where per_frame_clken is high, which implies href and vsync high.
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_Y;

  modport master (
    output per_frame_vsync,
    output per_frame_href,
    output per_frame_clken,
    output per_img_Y
  );

  modport slave (
    input per_frame_vsync,
    input per_frame_href,
    input per_frame_clken,
    input per_img_Y
  );
endinterface

// File: rtl/vip_pattern_pixel.sv
// Combinational test-pattern pixel: maps (pattern, const, x, y) to an 8-bit
// gray value. Ramps use the low byte of the coordinate, so they wrap at 256.
module vip_pattern_pixel
  import vip_pkg::*;
(
  input  logic [1:0] pattern_i,
  input  logic [7:0] const_y_i,
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic [7:0] pix_o
);

  always_comb begin
    pix_o = 8'h00;
    unique case (pattern_i)
      PAT_CONST: pix_o = const_y_i;
      PAT_HRAMP: pix_o = x_i;
      PAT_VRAMP: pix_o = y_i;
      PAT_CHECK: pix_o = (x_i[3] ^ y_i[3]) ? 8'hFF : 8'h00;
      default:   pix_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/vip_gray_stream_gen.sv
// Synthetic gray-frame source with camera front-end vsync/href/clken/Y timing.
// Whole frames only: enable is looked at in IDLE and at the end of V_BLANK.
module vip_gray_stream_gen
  import vip_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 160,
  parameter int VS_LEAD = 16,
  parameter int V_BLANK = 1000,
  parameter int CLK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  input  logic [7:0]                 const_Y,
  vip_gray_stream_gen_if.master      vid,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       busy,
  output state_t                     state_o
);

  localparam int XW    = cnt_width(IMG_W);
  localparam int YW    = cnt_width(IMG_H);
  localparam int DW    = cnt_width(CLK_DIV);
  localparam int CNT_N = (VS_LEAD > H_BLANK) ?
                         ((VS_LEAD > V_BLANK) ? VS_LEAD : V_BLANK) :
                         ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int CW    = cnt_width(CNT_N);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] VS_LAST = CW'(VS_LEAD - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [XW-1:0]   xpos_q, xpos_d;
  logic [YW-1:0]   ypos_q, ypos_d;
  logic [1:0]      pat_q, pat_d;
  logic [7:0]      cy_q, cy_d;

  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic            clken_q, clken_d;
  logic [7:0]      pix_q, pix_d;
  logic            fs_q, fs_d;
  logic            fd_q, fd_d;
  logic            busy_q, busy_d;
  logic [7:0]      pix_w;

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      pat_q   <= '0;
      cy_q    <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      pix_q   <= 8'h00;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      pat_q   <= pat_d;
      cy_q    <= cy_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      pix_q   <= pix_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: cnt_q times the lead/blank phases, div_q/xpos_q the active line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    pat_d   = pat_q;
    cy_d    = cy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_VS_LEAD;
          cnt_d   = '0;
          pat_d   = pattern_sel;
          cy_d    = const_Y;
        end
      end
      ST_VS_LEAD: begin
        if (cnt_q == VS_LAST) begin
          state_d = ST_LINE_ACT;
          cnt_d   = '0;
          div_d   = '0;
          xpos_d  = '0;
          ypos_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LINE_ACT: begin
        if (div_q == D_LAST) begin
          div_d = '0;
          if (xpos_q == X_LAST) begin
            state_d = ST_LINE_BLANK;
            cnt_d   = '0;
          end else begin
            xpos_d = xpos_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LINE_BLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          if (ypos_q == Y_LAST) begin
            state_d = ST_V_BLANK;
          end else begin
            state_d = ST_LINE_ACT;
            ypos_d  = ypos_q + 1'b1;
            xpos_d  = '0;
            div_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_V_BLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = ST_VS_LEAD;
            pat_d   = pattern_sel;
            cy_d    = const_Y;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vip_pattern_pixel u_pix (
    .pattern_i (pat_d),
    .const_y_i (cy_d),
    .x_i       (8'(xpos_d)),
    .y_i       (8'(ypos_d)),
    .pix_o     (pix_w)
  );

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    vsync_d = (state_d == ST_VS_LEAD) || (state_d == ST_LINE_ACT) ||
              (state_d == ST_LINE_BLANK);
    href_d  = (state_d == ST_LINE_ACT);
    clken_d = href_d && (div_d == '0);
    pix_d   = clken_d ? pix_w : 8'h00;
    fs_d    = (state_d == ST_VS_LEAD) && (state_q != ST_VS_LEAD);
    fd_d    = (state_d == ST_V_BLANK) && (state_q != ST_V_BLANK);
    busy_d  = (state_d != ST_IDLE);
  end

  assign vid.per_frame_vsync = vsync_q;
  assign vid.per_frame_href  = href_q;
  assign vid.per_frame_clken = clken_q;
  assign vid.per_img_Y       = pix_q;
  assign frame_start         = fs_q;
  assign frame_done          = fd_q;
  assign busy                = busy_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_vip_gray_stream_gen.sv
// Bench for vip_gray_stream_gen: two geometries driven in parallel, a
// frame-level timing model checked every cycle, plus literal frame checks.
module tb_vip_gray_stream_gen;
  import vip_pkg::*;

  localparam int AW = 4,  AH = 3,  AHB = 2, AVS = 3, AVB = 5, AD = 1;
  localparam int BW = 16, BH = 16, BHB = 3, BVS = 4, BVB = 6, BD = 3;

  typedef struct packed {
    int w; int h; int hb; int vs; int vb; int d;
  } geom_t;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_Y = 8'h00;
  int         cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vip_gray_stream_gen_if vid_a ();
  vip_gray_stream_gen_if vid_b ();
  logic   fs_a, fd_a, busy_a, fs_b, fd_b, busy_b;
  state_t st_a, st_b;

  vip_gray_stream_gen #(.IMG_W(AW), .IMG_H(AH), .H_BLANK(AHB), .VS_LEAD(AVS),
                        .V_BLANK(AVB), .CLK_DIV(AD)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .const_Y(const_Y), .vid(vid_a), .frame_start(fs_a), .frame_done(fd_a),
    .busy(busy_a), .state_o(st_a));

  vip_gray_stream_gen #(.IMG_W(BW), .IMG_H(BH), .H_BLANK(BHB), .VS_LEAD(BVS),
                        .V_BLANK(BVB), .CLK_DIV(BD)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .const_Y(const_Y), .vid(vid_b), .frame_start(fs_b), .frame_done(fd_b),
    .busy(busy_b), .state_o(st_b));

  logic [13:0] got_a, got_b;
  assign got_a = {vid_a.per_frame_vsync, vid_a.per_frame_href, vid_a.per_frame_clken,
                  vid_a.per_img_Y, fs_a, fd_a, busy_a};
  assign got_b = {vid_b.per_frame_vsync, vid_b.per_frame_href, vid_b.per_frame_clken,
                  vid_b.per_img_Y, fs_b, fd_b, busy_b};

  // ---------------- behavioural model ----------------
  function automatic geom_t geom(input int i);
    if (i == 0) return '{AW, AH, AHB, AVS, AVB, AD};
    return '{BW, BH, BHB, BVS, BVB, BD};
  endfunction

  function automatic int frame_len(input geom_t g);
    return g.vs + g.h * (g.w * g.d + g.hb) + g.vb;
  endfunction

  function automatic logic [7:0] ref_pix(input logic [1:0] p, input logic [7:0] c,
                                         input int x, input int y);
    case (p)
      2'd0:    return c;
      2'd1:    return 8'(x % 256);
      2'd2:    return 8'(y % 256);
      default: return ((((x / 8) % 2) != ((y / 8) % 2))) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Expected {vsync,href,clken,Y,frame_start,frame_done,busy} at frame offset t.
  function automatic logic [13:0] model_out(input geom_t g, input bit act, input int t,
                                            input logic [1:0] p, input logic [7:0] c);
    int lw, fe, u, ln, r;
    logic vs, hr, ck;
    logic [7:0] y;
    if (!act) return 14'd0;
    lw = g.w * g.d + g.hb;
    fe = g.vs + g.h * lw;
    vs = (t < fe);
    hr = 1'b0; ck = 1'b0; y = 8'h00;
    if (t >= g.vs && t < fe) begin
      u  = t - g.vs;
      ln = u / lw;
      r  = u % lw;
      if (r < g.w * g.d) begin
        hr = 1'b1;
        if (r % g.d == 0) begin
          ck = 1'b1;
          y  = ref_pix(p, c, r / g.d, ln);
        end
      end
    end
    return {vs, hr, ck, y, (t == 0), (t == fe), 1'b1};
  endfunction

  bit         m_act [2] = '{1'b0, 1'b0};
  int         m_t   [2] = '{0, 0};
  logic [1:0] m_pat [2] = '{2'd0, 2'd0};
  logic [7:0] m_cy  [2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
      end else if (!m_act[i]) begin
        if (enable) begin
          m_act[i] <= 1'b1; m_t[i] <= 0; m_pat[i] <= pattern_sel; m_cy[i] <= const_Y;
        end
      end else if (m_t[i] == frame_len(geom(i)) - 1) begin
        if (enable) begin
          m_t[i] <= 0; m_pat[i] <= pattern_sel; m_cy[i] <= const_Y;
        end else begin
          m_act[i] <= 1'b0;
        end
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;
  logic [7:0] exp_q[$];

  initial begin
    logic [13:0] e, a;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 2; i++) begin
          e = model_out(geom(i), m_act[i], m_t[i], m_pat[i], m_cy[i]);
          a = (i == 0) ? got_a : got_b;
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL stream dut%0d cycle %0d: got %h expected %h", i, cyc, a, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int         a_vs_cnt, a_busy_cnt, a_href_rise, a_fd_cnt, b_strobes;
  logic       a_href_prev = 1'b0;
  logic [7:0] a_y_q[$];
  int         a_fs_cyc[$];
  logic [7:0] b_pix [256];

  initial begin
    forever begin
      @(negedge clk);
      if (vid_a.per_frame_vsync) a_vs_cnt++;
      if (busy_a) a_busy_cnt++;
      if (vid_a.per_frame_href && !a_href_prev) a_href_rise++;
      a_href_prev = vid_a.per_frame_href;
      if (fd_a) a_fd_cnt++;
      if (fs_a) a_fs_cyc.push_back(cyc);
      if (vid_a.per_frame_clken) a_y_q.push_back(vid_a.per_img_Y);
      if (vid_b.per_frame_clken) begin
        if (b_strobes < 256) b_pix[b_strobes] = vid_b.per_img_Y;
        b_strobes++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    a_vs_cnt = 0; a_busy_cnt = 0; a_href_rise = 0; a_fd_cnt = 0; b_strobes = 0;
    a_y_q.delete(); a_fs_cyc.delete();
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int max);
    for (int k = 0; k < max; k++) begin
      tick(1);
      if (((i == 0) ? busy_a : busy_b) == 1'b0) return;
    end
    chk($sformatf("idle_timeout_dut%0d", i), 1, 0);
  endtask

  task automatic wait_href_a(input int max);
    for (int k = 0; k < max; k++) begin
      tick(1);
      if (vid_a.per_frame_href) return;
    end
    chk("href_timeout", 0, 1);
  endtask

  task automatic check_a_y(input string name);
    chk({name, "_count"}, a_y_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < a_y_q.size(); k++)
      chk($sformatf("%s_y%0d", name, k), a_y_q[k], exp_q[k]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;
    tick(2);
    cmp_en = 1'b1;
    tick(1);
    chk("reset_vsync", vid_a.per_frame_vsync, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_state", st_a, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // Horizontal ramp, one frame.
    clear_mon();
    pattern_sel = 2'd1;
    pulse_enable();
    wait_idle(0, 40);
    tick(2);
    chk("hramp_vsync_cycles", a_vs_cnt, 21);
    chk("hramp_frame_cycles", a_busy_cnt, 26);
    chk("hramp_href_pulses", a_href_rise, 3);
    chk("hramp_frame_done", a_fd_cnt, 1);
    chk("hramp_state_idle", st_a, ST_IDLE);
    exp_q.delete();
    for (int l = 0; l < 3; l++) for (int x = 0; x < 4; x++) exp_q.push_back(8'(x));
    check_a_y("hramp");
    wait_idle(1, 900);

    // Vertical ramp on both geometries.
    clear_mon();
    pattern_sel = 2'd2;
    pulse_enable();
    wait_idle(1, 900);
    exp_q.delete();
    for (int l = 0; l < 3; l++) for (int x = 0; x < 4; x++) exp_q.push_back(8'(l));
    check_a_y("vramp");
    chk("vramp_b_strobes", b_strobes, 256);
    chk("vramp_b_row0", b_pix[0], 0);
    chk("vramp_b_row1", b_pix[16], 1);
    chk("vramp_b_row15", b_pix[255], 15);

    // Constant with a mid-frame pattern change, then the latched checker.
    clear_mon();
    pattern_sel = 2'd0;
    const_Y = 8'hA5;
    pulse_enable();
    tick(8);
    pattern_sel = 2'd3;
    const_Y = 8'h3C;
    wait_idle(1, 900);
    exp_q.delete();
    repeat (12) exp_q.push_back(8'hA5);
    check_a_y("const");
    bad = 0;
    for (int k = 0; k < 256; k++) if (b_pix[k] != 8'hA5) bad++;
    chk("const_b_bad_pixels", bad, 0);

    clear_mon();
    pulse_enable();
    wait_idle(1, 900);
    exp_q.delete();
    repeat (12) exp_q.push_back(8'h00);
    check_a_y("check_small");
    chk("check_b_x0y0", b_pix[0], 8'h00);
    chk("check_b_x8y0", b_pix[8], 8'hFF);
    chk("check_b_x0y8", b_pix[128], 8'hFF);
    chk("check_b_x8y8", b_pix[136], 8'h00);
    chk("check_b_x15y15", b_pix[255], 8'h00);

    // Back-to-back frames, enable dropped mid third frame.
    clear_mon();
    pattern_sel = 2'(($urandom_range(0, 3)));
    enable = 1'b1;
    for (int k = 0; k < 200 && a_fs_cyc.size() < 3; k++) tick(1);
    tick(5);
    enable = 1'b0;
    wait_idle(0, 60);
    chk("b2b_starts", a_fs_cyc.size(), 3);
    if (a_fs_cyc.size() >= 3) begin
      chk("b2b_period1", a_fs_cyc[1] - a_fs_cyc[0], 26);
      chk("b2b_period2", a_fs_cyc[2] - a_fs_cyc[1], 26);
    end
    chk("b2b_frame_done", a_fd_cnt, 3);
    chk("b2b_strobes", a_y_q.size(), 36);
    wait_idle(1, 900);

    // Reset during an active line, then a clean restart.
    pulse_enable();
    wait_href_a(20);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_outputs_a", got_a, 0);
    chk("rst_outputs_b", got_b, 0);
    chk("rst_state_a", st_a, ST_IDLE);
    clear_mon();
    pattern_sel = 2'd1;
    pulse_enable();
    wait_idle(0, 40);
    chk("restart_vsync_cycles", a_vs_cnt, 21);
    chk("restart_strobes", a_y_q.size(), 12);
    if (a_y_q.size() > 0) chk("restart_first_y", a_y_q[0], 0);

    // Randomized phases against the model.
    for (int ph = 0; ph < 15; ph++) begin
      int en_bias;
      en_bias = $urandom_range(0, 3);
      repeat (200) begin
        tick(1);
        enable      = ($urandom_range(0, 3) < en_bias);
        pattern_sel = 2'($urandom_range(0, 3));
        const_Y     = 8'($urandom_range(0, 255));
        rst_n       = ($urandom_range(0, 299) != 0);
      end
    end
    rst_n = 1'b1;
    enable = 1'b0;
    wait_idle(1, 900);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vip_gray_stream_gen.md
# vip_gray_stream_gen

Source end of the VIP gray-video stream: generates a synthetic 8-bit gray frame with the same vsync/href/clken/Y timing the camera front-end delivers to the VIP filter chain (3x3 matrix generator, median filter). It drives filter inputs for bring-up, board self-test and regression benches without a sensor. Frame geometry, blanking and pixel rate are parameters; the pattern is selected at run time.

## Interface
- IMG_W, 640: active pixels per line (>=2)
- IMG_H, 480: active lines per frame (>=2)
- H_BLANK, 160: cycles with href low after each active line (>=1)
- VS_LEAD, 16: cycles with vsync high before the first line (>=1)
- V_BLANK, 1000: cycles with vsync low after the last line (>=1)
- CLK_DIV, 1: clock cycles per pixel (>=1)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run request; level-sensitive
- pattern_sel  in  2  0 constant, 1 horizontal ramp, 2 vertical ramp, 3 checker
- const_Y  in  8  value for pattern 0
- per_frame_vsync  out  1  frame valid
- per_frame_href  out  1  line valid
- per_frame_clken  out  1  pixel strobe
- per_img_Y  out  8  gray pixel, valid only with clken
- frame_start  out  1  one-cycle pulse, first cycle of vsync high
- frame_done  out  1  one-cycle pulse, first cycle of V_BLANK
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, VS_LEAD, LINE_ACT, LINE_BLANK, V_BLANK.
- IDLE: all stream outputs 0. enable=1 -> VS_LEAD; latch pattern_sel and const_Y; pulse frame_start.
- VS_LEAD: vsync=1, href=0 for VS_LEAD cycles -> LINE_ACT with y=0.
- LINE_ACT: vsync=1, href=1 for IMG_W*CLK_DIV cycles. Divider div counts 0..CLK_DIV-1; clken=1 when div==0; x increments after each strobe, x=0..IMG_W-1. -> LINE_BLANK.
- LINE_BLANK: vsync=1, href=0, H_BLANK cycles. If y==IMG_H-1 -> V_BLANK (pulse frame_done), else y+1 -> LINE_ACT.
- V_BLANK: all stream outputs 0, V_BLANK cycles. Then enable=1 -> VS_LEAD (relatch, pulse frame_start); else IDLE.
- enable low mid-frame: current frame completes in full; no truncated frames.
- pattern_sel/const_Y changes mid-frame: ignored until next latch.
- Pixel function (x,y of the strobed pixel): 0 const_Y; 1 x[7:0]; 2 y[7:0]; 3 (x[3]^y[3]) ? 8'hFF : 8'h00. Wrap modulo 256 for ramps.
- per_img_Y = 0 whenever clken=0.
- Counters sized $clog2(max+1); no overflow at any legal parameter set.

## Timing
- All outputs registered; reset (rst_n=0 at a clk edge) forces state IDLE, counters 0, every output 0 on the following cycle, including mid-frame.
- enable sampled high in IDLE at edge n -> vsync, frame_start high from cycle n+1.
- First clken at cycle VS_LEAD after vsync rises.
- Frame length (vsync rise to next possible rise) = VS_LEAD + IMG_H*(IMG_W*CLK_DIV + H_BLANK) + V_BLANK cycles; exactly IMG_W*IMG_H clken strobes per frame.
- href and vsync fall together at the end of the last line's active period? No: vsync stays high through the last LINE_BLANK and falls on V_BLANK entry.
- Back-to-back frames with enable held high: no idle gap beyond V_BLANK.

## Structure
- vip_pkg: pattern select localparams (PAT_CONST, PAT_HRAMP, PAT_VRAMP, PAT_CHECK) and state encoding.
- One sub-module: vip_pattern_pixel, combinational (pattern, const_Y, x, y) -> Y; reused by benches as the reference model.
- Top holds FSM, divider, x/y and phase counters, output registers.

## Test plan
- IMG_W=4, IMG_H=3, H_BLANK=2, VS_LEAD=3, V_BLANK=5, CLK_DIV=1, pattern 1, enable one frame -> vsync high 21 cycles, 3 href pulses of 4 cycles, Y=0,1,2,3 per line, frame_done once, 26-cycle frame, returns IDLE.
- Same, CLK_DIV=3, pattern 2 -> href 12 cycles each, clken every 3rd cycle, Y=0 then 1 then 2 by line, 12 strobes total.
- pattern 0, const_Y=8'hA5, pattern_sel switched to 3 mid-frame -> all 12 pixels 8'hA5; next frame uses checker.
- IMG_W=IMG_H=16, pattern 3 -> Y=8'h00 for x,y<8, 8'hFF for x>=8 y<8, 8'h00 for x>=8 y>=8.
- enable held high 3 frames -> frame_start period exactly 26 cycles; enable dropped mid-frame 2 -> frame 2 completes, then IDLE.
- rst_n low for one cycle during LINE_ACT -> next cycle all outputs 0, busy 0; enable high restarts clean frame from VS_LEAD.
